// File: rtl/log_ram_writer_if.sv
// log_ram_writer_if
//   Groups the log-word stream and the Avalon-MM write port of the log RAM.
//   modport master : writer side (consumes the stream, masters the RAM port)
//   modport slave  : environment side (stream source + RAM slave)
//   Signals: in_data/in_valid/in_ready  - log word stream
//            ram_address/ram_chipselect/ram_write/ram_byteenable/ram_writedata
interface log_ram_writer_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [1:0]        ram_byteenable;
    logic [DATA_W-1:0] ram_writedata;

    modport master (
        input  in_data, in_valid,
        output in_ready, ram_address, ram_chipselect, ram_write,
               ram_byteenable, ram_writedata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, ram_address, ram_chipselect, ram_write,
               ram_byteenable, ram_writedata
    );
endinterface

// File: rtl/log_ram_writer.sv
// log_ram_writer
//   Writes a valid/ready stream of 16-bit log words to consecutive addresses
//   of the on-chip log RAM, one-shot or circular.
//   Ports: clk, reset_n (sync, active low), arm/stop pulses, wrap_en,
//          bus (log_ram_writer_if.master: stream in, RAM write port out),
//          wr_ptr (next address), wrapped, busy (LOG), done (DONE).
//   Optional macro LOG_WRITER_TIMESTAMP_EN: each data word is followed by a
//   second RAM write holding a free-running 16-bit cycle count taken at the
//   accept.
//
//   state  | meaning
//   IDLE   | after reset, nothing captured
//   LOG    | capturing, in_ready high (except on a timestamp cycle)
//   DONE   | capture ended (stop or full one-shot), pointer held for readback
module log_ram_writer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              stop,
    input  logic              wrap_en,
    log_ram_writer_if.master  bus,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {S_IDLE, S_LOG, S_DONE} state_t;

    state_t            state_q;
    logic              wrap_mode_q;
    logic              wrapped_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              ram_cs_q;
    logic              accept;
    logic              last_word;

`ifdef LOG_WRITER_TIMESTAMP_EN
    logic [15:0] ts_cnt_q;
    logic [15:0] ts_val_q;
    logic        ts_pend_q;
    logic        stop_pend_q;

    assign bus.in_ready = (state_q == S_LOG) && !ts_pend_q;
`else
    assign bus.in_ready = (state_q == S_LOG);
`endif

    assign accept    = bus.in_valid & bus.in_ready;
    assign last_word = (wr_ptr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wrap_mode_q <= 1'b0;
            wrapped_q   <= 1'b0;
            wr_ptr_q    <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_cs_q    <= 1'b0;
`ifdef LOG_WRITER_TIMESTAMP_EN
            ts_cnt_q    <= '0;
            ts_val_q    <= '0;
            ts_pend_q   <= 1'b0;
            stop_pend_q <= 1'b0;
`endif
        end else begin
            ram_cs_q <= 1'b0;
`ifdef LOG_WRITER_TIMESTAMP_EN
            ts_cnt_q <= ts_cnt_q + 16'd1;
`endif
            case (state_q)
                S_LOG: begin
                    if (arm) begin
                        // restart; a word offered this cycle is dropped
                        wr_ptr_q    <= '0;
                        wrapped_q   <= 1'b0;
                        wrap_mode_q <= wrap_en;
`ifdef LOG_WRITER_TIMESTAMP_EN
                        ts_pend_q   <= 1'b0;
                        stop_pend_q <= 1'b0;
                    end else if (ts_pend_q) begin
                        // second half of an entry: the wrap/full check lives here
                        ram_cs_q    <= 1'b1;
                        ram_addr_q  <= wr_ptr_q;
                        ram_data_q  <= ts_val_q;
                        wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
                        ts_pend_q   <= 1'b0;
                        stop_pend_q <= 1'b0;
                        if (last_word && !wrap_mode_q) begin
                            state_q <= S_DONE;
                        end else begin
                            if (last_word) wrapped_q <= 1'b1;
                            if (stop || stop_pend_q) state_q <= S_DONE;
                        end
                    end else if (accept) begin
                        ram_cs_q    <= 1'b1;
                        ram_addr_q  <= wr_ptr_q;
                        ram_data_q  <= bus.in_data;
                        wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
                        ts_pend_q   <= 1'b1;
                        ts_val_q    <= ts_cnt_q;
                        // a stop with the data word still lets its timestamp go out
                        stop_pend_q <= stop;
`else
                    end else if (accept) begin
                        ram_cs_q   <= 1'b1;
                        ram_addr_q <= wr_ptr_q;
                        ram_data_q <= bus.in_data;
                        wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
                        if (last_word) begin
                            if (wrap_mode_q) wrapped_q <= 1'b1;
                            else             state_q   <= S_DONE;
                        end
                        if (stop) state_q <= S_DONE;
`endif
                    end else if (stop) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    if (arm) begin
                        state_q     <= S_LOG;
                        wr_ptr_q    <= '0;
                        wrapped_q   <= 1'b0;
                        wrap_mode_q <= wrap_en;
                    end
                end
            endcase
        end
    end

    assign bus.ram_address    = ram_addr_q;
    assign bus.ram_writedata  = ram_data_q;
    assign bus.ram_chipselect = ram_cs_q;
    assign bus.ram_write      = ram_cs_q;
    assign bus.ram_byteenable = {2{ram_cs_q}};

    assign wr_ptr  = wr_ptr_q;
    assign wrapped = wrapped_q;
    assign busy    = (state_q == S_LOG);
    assign done    = (state_q == S_DONE);
endmodule

// File: tb/tb_log_ram_writer.sv
module tb_log_ram_writer;
    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        stop;
    logic        wrap_en;
    logic [13:0] wr_ptr;
    logic        wrapped;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int dead_cnt = 0;
    int six_cnt = 0;

    logic [15:0] mem [16384];

    log_ram_writer_if #(.ADDR_W(14), .DATA_W(16)) bus ();

    log_ram_writer #(.ADDR_W(14), .DATA_W(16), .DEPTH(16384)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (arm),
        .stop    (stop),
        .wrap_en (wrap_en),
        .bus     (bus.master),
        .wr_ptr  (wr_ptr),
        .wrapped (wrapped),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave model
    always @(posedge clk) begin
        if (bus.ram_write === 1'b1) begin
            mem[bus.ram_address] = bus.ram_writedata;
            if (bus.ram_writedata == 16'hDEAD) dead_cnt++;
            if (bus.ram_writedata == 16'h6666) six_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_in_ready"},   32'(bus.in_ready), 32'd0);
        check({pfx, "_cs"},         32'(bus.ram_chipselect), 32'd0);
        check({pfx, "_write"},      32'(bus.ram_write), 32'd0);
        check({pfx, "_be"},         32'(bus.ram_byteenable), 32'd0);
        check({pfx, "_addr"},       32'(bus.ram_address), 32'd0);
        check({pfx, "_wdata"},      32'(bus.ram_writedata), 32'd0);
        check({pfx, "_wr_ptr"},     32'(wr_ptr), 32'd0);
        check({pfx, "_wrapped"},    32'(wrapped), 32'd0);
        check({pfx, "_busy"},       32'(busy), 32'd0);
        check({pfx, "_done"},       32'(done), 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        arm         = 1'b0;
        stop        = 1'b0;
        wrap_en     = 1'b0;
        bus.in_data = 16'h0;
        bus.in_valid = 1'b0;
        step(); step(); step();
        reset_checks("rst");
        reset_n = 1'b1;
        step();

        // one-shot, 5 words, stop
        arm = 1'b1; wrap_en = 1'b0;
        step();
        arm = 1'b0;
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i + 1);
            step();
            check("t1_wr_latency", 32'(bus.ram_write), 32'd1);
            check("t1_wr_be", 32'(bus.ram_byteenable), 32'd3);
            check("t1_wr_addr", 32'(bus.ram_address), 32'(i));
            check("t1_wr_data", 32'(bus.ram_writedata), 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t1_no_write", 32'(bus.ram_write), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_wrapped", 32'(wrapped), 32'd0);
        check("t1_wr_ptr", 32'(wr_ptr), 32'd5);
        for (int i = 0; i < 5; i++)
            check("t1_mem", 32'(mem[i]), 32'(i + 1));

        // one-shot fill to the end
        arm = 1'b1; wrap_en = 1'b0;
        step();
        arm = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            bus.in_data = 16'(i);
            step();
        end
        check("t2_last_addr", 32'(bus.ram_address), 32'h3FFF);
        check("t2_last_data", 32'(bus.ram_writedata), 32'h3FFF);
        check("t2_last_write", 32'(bus.ram_write), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_data = 16'h4000;
        step();
        check("t2_extra_write", 32'(bus.ram_write), 32'd0);
        check("t2_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t2_wrapped", 32'(wrapped), 32'd0);
        check("t2_done_hold", 32'(done), 32'd1);
        check("t2_mem_last", 32'(mem[16383]), 32'h3FFF);
        bus.in_valid = 1'b0;

        // circular, 16386 words
        arm = 1'b1; wrap_en = 1'b1;
        step();
        arm = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16386; i++) begin
            bus.in_data = 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("t3_wrapped", 32'(wrapped), 32'd1);
        check("t3_wr_ptr", 32'(wr_ptr), 32'd2);
        check("t3_busy", 32'(busy), 32'd1);
        step();
        check("t3_mem0", 32'(mem[0]), 32'h4000);
        check("t3_mem1", 32'(mem[1]), 32'h4001);

        // stop together with a word at wr_ptr=3
        bus.in_valid = 1'b1; bus.in_data = 16'h1111;
        step();
        check("t4_wr_ptr3", 32'(wr_ptr), 32'd3);
        bus.in_data = 16'hBEEF; stop = 1'b1;
        step();
        stop = 1'b0; bus.in_valid = 1'b0;
        check("t4_write", 32'(bus.ram_write), 32'd1);
        check("t4_addr", 32'(bus.ram_address), 32'd3);
        check("t4_data", 32'(bus.ram_writedata), 32'hBEEF);
        check("t4_done", 32'(done), 32'd1);
        check("t4_wr_ptr", 32'(wr_ptr), 32'd4);
        step();
        check("t4_mem3", 32'(mem[3]), 32'hBEEF);

        // arm together with a word at wr_ptr=10
        dead_cnt = 0;
        arm = 1'b1; wrap_en = 1'b0;
        step();
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h0100 + i);
            step();
        end
        check("t5_wr_ptr10", 32'(wr_ptr), 32'd10);
        arm = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
        step();
        arm = 1'b0; bus.in_valid = 1'b0;
        check("t5_no_write", 32'(bus.ram_write), 32'd0);
        check("t5_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t5_wrapped", 32'(wrapped), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        step();
        check("t5_dead_writes", 32'(dead_cnt), 32'd0);

        // reset mid-capture on the cycle after an accept
        six_cnt = 0;
        bus.in_valid = 1'b1; bus.in_data = 16'h5555;
        step();
        check("t6_accept_write", 32'(bus.ram_write), 32'd1);
        reset_n = 1'b0; bus.in_data = 16'h6666;
        step();
        reset_checks("t6");
        reset_n = 1'b1; bus.in_valid = 1'b0;
        step();
        check("t6_six_writes", 32'(six_cnt), 32'd0);
        check("t6_mem0_kept", 32'(mem[0]), 32'h5555);

        // stop outside LOG, then arm+stop together
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t7_stop_idle_busy", 32'(busy), 32'd0);
        check("t7_stop_idle_done", 32'(done), 32'd0);
        arm = 1'b1; stop = 1'b1;
        step();
        arm = 1'b0; stop = 1'b0;
        check("t7_arm_wins_busy", 32'(busy), 32'd1);
        check("t7_arm_wins_done", 32'(done), 32'd0);
        step();
        check("t7_in_ready", 32'(bus.in_ready), 32'd1);
        arm = 1'b1; stop = 1'b1;
        step();
        arm = 1'b0; stop = 1'b0;
        check("t7_arm_wins_in_log", 32'(busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
